// File: rtl/ow_scratchpad_reader.sv
// 1-Wire master read engine: issues 8*NBYTES read slots, streams each sampled bit
// into an external CRC8 register, assembles the scratchpad and flags crc_ok.
module ow_scratchpad_reader #(
  parameter int NBYTES   = 9,
  parameter int T_LOW    = 100,
  parameter int T_SAMPLE = 650,
  parameter int T_SLOT   = 3500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_dq_in,
  output logic                  o_dq_oe,
  output logic                  o_crc_rst,
  output logic                  o_crc_bit,
  output logic                  o_crc_en,
  input  logic [7:0]            i_crc_val,
  output logic [8*NBYTES-1:0]   o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_crc_ok
);

  localparam int NBITS = 8 * NBYTES;
  localparam int CNT_W = $clog2(T_SLOT);
  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CNT_W-1:0] C_LOW_END  = CNT_W'(T_LOW - 1);
  localparam logic [CNT_W-1:0] C_SAMPLE   = CNT_W'(T_SAMPLE);
  localparam logic [CNT_W-1:0] C_SLOT_END = CNT_W'(T_SLOT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] C_LAST_BIT = IDX_W'(NBITS - 1);
  localparam logic [IDX_W-1:0] C_IDX_ONE  = IDX_W'(1);

  // IDLE wait start | CLR clear CRC | SLOT run read slots | CHECK latch crc_ok | DONE pulse done
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_SLOT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic               r_dq_s1;
  logic               r_dq_s2;
  logic               r_dq_oe;
  logic               r_crc_rst;
  logic               r_crc_bit;
  logic               r_crc_en;
  logic [NBITS-1:0]   r_data;
  logic               r_busy;
  logic               r_done;
  logic               r_crc_ok;

  logic w_low_end;
  logic w_sample;
  logic w_slot_end;
  logic w_last_bit;

  assign w_low_end  = (r_cnt == C_LOW_END);
  assign w_sample   = (r_cnt == C_SAMPLE);
  assign w_slot_end = (r_cnt == C_SLOT_END);
  assign w_last_bit = (r_idx == C_LAST_BIT);

  // Idle-high line, so the synchronizer resets to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq_s1 <= 1'b1;
      r_dq_s2 <= 1'b1;
    end else begin
      r_dq_s1 <= i_dq_in;
      r_dq_s2 <= r_dq_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_dq_oe   <= 1'b0;
      r_crc_rst <= 1'b0;
      r_crc_bit <= 1'b0;
      r_crc_en  <= 1'b0;
      r_data    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc_ok  <= 1'b0;
    end else begin
      r_crc_rst <= 1'b0;
      r_crc_en  <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state   <= S_CLR;
            r_busy    <= 1'b1;
            r_crc_ok  <= 1'b0;
            r_crc_rst <= 1'b1;
          end
        end
        S_CLR: begin
          r_idx   <= '0;
          r_cnt   <= '0;
          r_dq_oe <= 1'b1;
          r_state <= S_SLOT;
        end
        S_SLOT: begin
          if (w_sample) begin
            r_data[r_idx] <= r_dq_s2;
            r_crc_bit     <= r_dq_s2;
            r_crc_en      <= 1'b1;
          end
          // dq_oe is registered in step with cnt so it is high exactly for cnt 0..T_LOW-1.
          if (w_slot_end) begin
            if (w_last_bit) begin
              r_dq_oe <= 1'b0;
              r_state <= S_CHECK;
            end else begin
              r_idx   <= r_idx + C_IDX_ONE;
              r_cnt   <= '0;
              r_dq_oe <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + C_CNT_ONE;
            if (w_low_end) begin
              r_dq_oe <= 1'b0;
            end
          end
        end
        S_CHECK: begin
          r_crc_ok <= (i_crc_val == 8'h00);
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_dq_oe <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_dq_oe   = r_dq_oe;
  assign o_crc_rst = r_crc_rst;
  assign o_crc_bit = r_crc_bit;
  assign o_crc_en  = r_crc_en;
  assign o_data    = r_data;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_crc_ok  = r_crc_ok;

endmodule

// File: tb/tb_ow_scratchpad_reader.sv
// Bench for ow_scratchpad_reader: DS18B20-style slave model and Dallas CRC8 register
// around a 9-byte and a 1-byte instance, checked against a bit-level reference.
module tb_ow_scratchpad_reader;
  localparam int T_LOW    = 4;
  localparam int T_SAMPLE = 20;
  localparam int T_SLOT   = 60;
  localparam int NB       = 9;
  localparam int NBITS    = 8 * NB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 9-byte instance
  logic        a_start = 1'b0;
  logic        a_dq_in, a_dq_oe, a_crc_rst, a_crc_bit, a_crc_en, a_busy, a_done, a_crc_ok;
  logic [7:0]  a_crc = 8'h00;
  logic [71:0] a_data;
  logic [71:0] a_pat = '0;
  int          a_ptr = 0;
  logic        a_prev_oe = 1'b0;

  // 1-byte instance
  logic        b_start = 1'b0;
  logic        b_dq_in, b_dq_oe, b_crc_rst, b_crc_bit, b_crc_en, b_busy, b_done, b_crc_ok;
  logic [7:0]  b_crc = 8'h00;
  logic [7:0]  b_data;
  logic [7:0]  b_pat = '0;
  int          b_ptr = 0;
  logic        b_prev_oe = 1'b0;

  ow_scratchpad_reader #(.NBYTES(NB), .T_LOW(T_LOW), .T_SAMPLE(T_SAMPLE), .T_SLOT(T_SLOT)) u_dut9 (
    .clk(clk), .rst(rst), .i_start(a_start), .i_dq_in(a_dq_in), .o_dq_oe(a_dq_oe),
    .o_crc_rst(a_crc_rst), .o_crc_bit(a_crc_bit), .o_crc_en(a_crc_en), .i_crc_val(a_crc),
    .o_data(a_data), .o_busy(a_busy), .o_done(a_done), .o_crc_ok(a_crc_ok));

  ow_scratchpad_reader #(.NBYTES(1), .T_LOW(T_LOW), .T_SAMPLE(T_SAMPLE), .T_SLOT(T_SLOT)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(b_start), .i_dq_in(b_dq_in), .o_dq_oe(b_dq_oe),
    .o_crc_rst(b_crc_rst), .o_crc_bit(b_crc_bit), .o_crc_en(b_crc_en), .i_crc_val(b_crc),
    .o_data(b_data), .o_busy(b_busy), .o_done(b_done), .o_crc_ok(b_crc_ok));

  // Slave: once the master releases the line it presents the next pattern bit.
  always @(posedge clk) begin
    if (a_crc_rst) a_ptr <= 0;
    else if (a_prev_oe && !a_dq_oe) a_ptr <= a_ptr + 1;
    a_prev_oe <= a_dq_oe;
    if (b_crc_rst) b_ptr <= 0;
    else if (b_prev_oe && !b_dq_oe) b_ptr <= b_ptr + 1;
    b_prev_oe <= b_dq_oe;
  end
  assign a_dq_in = a_dq_oe ? 1'b0 : ((a_ptr >= 1 && a_ptr <= 72) ? a_pat[a_ptr-1] : 1'b1);
  assign b_dq_in = b_dq_oe ? 1'b0 : ((b_ptr >= 1 && b_ptr <= 8) ? b_pat[b_ptr-1] : 1'b1);

  // Attached Dallas/Maxim CRC8 registers (reflected 0x31 = 0x8C).
  always @(posedge clk) begin
    if (rst || a_crc_rst) a_crc <= 8'h00;
    else if (a_crc_en) a_crc <= (a_crc >> 1) ^ (((a_crc[0] ^ a_crc_bit) != 1'b0) ? 8'h8C : 8'h00);
    if (rst || b_crc_rst) b_crc <= 8'h00;
    else if (b_crc_en) b_crc <= (b_crc >> 1) ^ (((b_crc[0] ^ b_crc_bit) != 1'b0) ? 8'h8C : 8'h00);
  end

  // Slot-timing monitor on the 9-byte instance, sampled mid-cycle.
  longint cyc = 0;
  longint last_start = -1;
  longint crst_cyc = -100;
  int oe_len = 0, oe_runs = 0, bad_len = 0, bad_gap = 0;
  int en_cnt = 0, bad_en = 0, crst_cnt = 0, bad_crst = 0, b_en_cnt = 0;
  logic mon_prev_oe = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (b_crc_en) b_en_cnt++;
    if (rst) begin
      mon_prev_oe = 1'b0;
      last_start  = -1;
      oe_len      = 0;
    end else begin
      if (a_crc_rst) begin
        crst_cnt++;
        crst_cyc   = cyc;
        last_start = -1;
        if (a_dq_oe || a_crc_en) bad_crst++;
      end
      if (a_dq_oe && !mon_prev_oe) begin
        oe_runs++;
        if (last_start < 0) begin
          if (cyc - crst_cyc != 1) bad_gap++;
        end else if (cyc - last_start != T_SLOT) bad_gap++;
        last_start = cyc;
        oe_len     = 0;
      end
      if (a_dq_oe) oe_len++;
      else if (mon_prev_oe && oe_len != T_LOW) bad_len++;
      // crc_en is registered on the sample cycle, so it shows one cycle later.
      if (a_crc_en) begin
        en_cnt++;
        if (last_start < 0 || cyc - last_start != T_SAMPLE + 1) bad_en++;
      end
      mon_prev_oe = a_dq_oe;
    end
  end

  function automatic logic [7:0] crc_ref(input logic [71:0] d, input int nbits);
    logic [7:0] c;
    logic fb;
    c = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      fb = c[0] ^ d[k];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  function automatic logic [71:0] rand_valid();
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'($urandom);
    d[71:64] = crc_ref(d, 64);
    return d;
  endfunction

  task automatic run_txn(input bit sel, input int restart_at, input bit start_on_done,
                         output int n_done, output int n_dones, output int busy_late,
                         output bit busy_clr, output logic [71:0] data_clr);
    int nbits;
    int budget;
    int n;
    nbits  = sel ? 8 : NBITS;
    budget = 1 + nbits * T_SLOT + 2 + 2 * T_SLOT;
    n = 1;
    n_done = -1; n_dones = 0; busy_late = 0;
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; b_start = 1'b0;
    busy_clr = sel ? b_busy : a_busy;
    data_clr = sel ? {64'b0, b_data} : a_data;
    while (n < budget && !(n_done >= 0 && n >= n_done + 2 * T_SLOT)) begin
      if (sel ? b_done : a_done) begin
        n_dones++;
        if (n_done < 0) begin
          n_done = n;
          if (start_on_done) begin
            if (sel) b_start = 1'b1; else a_start = 1'b1;
          end
        end
      end
      if (n_done >= 0 && (sel ? b_busy : a_busy)) busy_late++;
      if (n == restart_at) begin
        if (sel) b_start = 1'b1; else a_start = 1'b1;
      end
      @(posedge clk); #1;
      a_start = 1'b0; b_start = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_dq_oe, a_crc_rst, a_crc_bit, a_crc_en, a_busy, a_done, a_crc_ok} !== 7'b0 || a_data !== '0) begin
      errors++;
      $display("FAIL reset_dut9: outputs=%b data=%h expected all zero",
               {a_dq_oe, a_crc_rst, a_crc_bit, a_crc_en, a_busy, a_done, a_crc_ok}, a_data);
    end
    checks++;
    if ({b_dq_oe, b_crc_rst, b_crc_bit, b_crc_en, b_busy, b_done, b_crc_ok} !== 7'b0 || b_data !== '0) begin
      errors++;
      $display("FAIL reset_dut1: outputs=%b data=%h expected all zero",
               {b_dq_oe, b_crc_rst, b_crc_bit, b_crc_en, b_busy, b_done, b_crc_ok}, b_data);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_known_vector();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    a_pat = 72'h1C_10_0C_FF_7F_46_4B_05_50;
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (nd != 1 + NBITS * T_SLOT + 2) begin
      errors++; $display("FAIL known_done_cycle: got %0d expected %0d", nd, 1 + NBITS * T_SLOT + 2);
    end
    checks++;
    if (a_data !== 72'h1C_10_0C_FF_7F_46_4B_05_50) begin
      errors++; $display("FAIL known_data: got %h expected 1c100cff7f464b0550", a_data);
    end
    checks++;
    if (a_crc_ok !== 1'b1) begin errors++; $display("FAIL known_crc_ok: got %b expected 1", a_crc_ok); end
    checks++;
    if (bc !== 1'b1 || ndn != 1 || bl != 0) begin
      errors++; $display("FAIL known_busy_done: busy_at_clr=%b dones=%0d busy_after_done=%0d expected 1/1/0", bc, ndn, bl);
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (a_data !== 72'h1C_10_0C_FF_7F_46_4B_05_50 || a_crc_ok !== 1'b1) begin
      errors++; $display("FAIL known_hold: data=%h crc_ok=%b expected held values", a_data, a_crc_ok);
    end
  endtask

  task automatic test_bad_crc();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    a_pat = 72'h1C_10_0C_FF_7F_46_4A_05_50;
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (dc !== 72'h1C_10_0C_FF_7F_46_4B_05_50) begin
      errors++; $display("FAIL bad_data_at_start: got %h expected previous scratchpad", dc);
    end
    checks++;
    if (nd != 1 + NBITS * T_SLOT + 2) begin
      errors++; $display("FAIL bad_done_cycle: got %0d expected %0d", nd, 1 + NBITS * T_SLOT + 2);
    end
    checks++;
    if (a_data !== 72'h1C_10_0C_FF_7F_46_4A_05_50 || a_crc_ok !== 1'b0) begin
      errors++; $display("FAIL bad_crc_result: data=%h crc_ok=%b expected ...4a0550 / 0", a_data, a_crc_ok);
    end
  endtask

  task automatic test_slot_timing();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    int s_runs, s_len, s_gap, s_en, s_ben, s_crst, s_bcrst;
    s_runs = oe_runs; s_len = bad_len; s_gap = bad_gap; s_en = en_cnt;
    s_ben = bad_en; s_crst = crst_cnt; s_bcrst = bad_crst;
    a_pat = rand_valid();
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (oe_runs - s_runs != NBITS || bad_len != s_len || bad_gap != s_gap) begin
      errors++; $display("FAIL slot_oe_runs: runs=%0d bad_len=%0d bad_gap=%0d expected %0d/0/0",
                         oe_runs - s_runs, bad_len - s_len, bad_gap - s_gap, NBITS);
    end
    checks++;
    if (en_cnt - s_en != NBITS || bad_en != s_ben) begin
      errors++; $display("FAIL slot_crc_en: pulses=%0d misplaced=%0d expected %0d/0", en_cnt - s_en, bad_en - s_ben, NBITS);
    end
    checks++;
    if (crst_cnt - s_crst != 1 || bad_crst != s_bcrst) begin
      errors++; $display("FAIL slot_crc_rst: pulses=%0d overlaps=%0d expected 1/0", crst_cnt - s_crst, bad_crst - s_bcrst);
    end
    checks++;
    if (a_data !== a_pat || a_crc_ok !== (crc_ref(a_pat, NBITS) == 8'h00)) begin
      errors++; $display("FAIL slot_result: data=%h crc_ok=%b expected %h/1", a_data, a_crc_ok, a_pat);
    end
  endtask

  task automatic test_rst_mid();
    int n;
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    a_pat = rand_valid();
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    n = 1;
    while (n < 2 + 30 * T_SLOT + 1) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (a_dq_oe !== 1'b1 || a_busy !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: dq_oe=%b busy=%b expected 1/1", a_dq_oe, a_busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_dq_oe, a_busy, a_done, a_crc_ok, a_crc_en, a_crc_rst, a_crc_bit} !== 7'b0 || a_data !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: outputs=%b data=%h expected all zero",
                         {a_dq_oe, a_busy, a_done, a_crc_ok, a_crc_en, a_crc_rst, a_crc_bit}, a_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    a_pat = rand_valid();
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (nd != 1 + NBITS * T_SLOT + 2 || a_data !== a_pat || a_crc_ok !== 1'b1) begin
      errors++; $display("FAIL rst_mid_fresh: done_cycle=%0d data=%h crc_ok=%b expected %0d/%h/1",
                         nd, a_data, a_crc_ok, 1 + NBITS * T_SLOT + 2, a_pat);
    end
  endtask

  task automatic test_zero_one();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    a_pat = '0;
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (a_data !== '0 || a_crc_ok !== 1'b1) begin
      errors++; $display("FAIL all_zero: data=%h crc_ok=%b expected 0/1", a_data, a_crc_ok);
    end
    a_pat = '1;
    run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
    checks++;
    if (a_data !== {72{1'b1}} || a_crc_ok !== 1'b0) begin
      errors++; $display("FAIL all_one: data=%h crc_ok=%b expected all ones/0", a_data, a_crc_ok);
    end
  endtask

  task automatic test_random();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    logic exp_ok;
    for (int i = 0; i < 3; i++) begin
      a_pat = (i % 2 == 0) ? rand_valid() : 72'({$urandom(), $urandom(), $urandom()});
      exp_ok = (crc_ref(a_pat, NBITS) == 8'h00);
      run_txn(1'b0, -1, 1'b0, nd, ndn, bl, bc, dc);
      checks++;
      if (a_data !== a_pat || a_crc_ok !== exp_ok || nd != 1 + NBITS * T_SLOT + 2) begin
        errors++; $display("FAIL random_%0d: data=%h crc_ok=%b done_cycle=%0d expected %h/%b/%0d",
                           i, a_data, a_crc_ok, nd, a_pat, exp_ok, 1 + NBITS * T_SLOT + 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    a_pat = rand_valid();
    run_txn(1'b0, 2 + 10 * T_SLOT + 5, 1'b1, nd, ndn, bl, bc, dc);
    checks++;
    if (nd != 1 + NBITS * T_SLOT + 2 || ndn != 1 || bl != 0) begin
      errors++; $display("FAIL restart_ignored: done_cycle=%0d dones=%0d busy_after_done=%0d expected %0d/1/0",
                         nd, ndn, bl, 1 + NBITS * T_SLOT + 2);
    end
    checks++;
    if (a_data !== a_pat || a_crc_ok !== 1'b1) begin
      errors++; $display("FAIL restart_result: data=%h crc_ok=%b expected %h/1", a_data, a_crc_ok, a_pat);
    end
  endtask

  task automatic test_nbytes1();
    int nd, ndn, bl; bit bc; logic [71:0] dc;
    int s_en;
    logic exp_ok;
    for (int i = 0; i < 3; i++) begin
      b_pat = (i == 0) ? 8'hA5 : ((i == 1) ? 8'($urandom) : 8'h00);
      exp_ok = (crc_ref({64'b0, b_pat}, 8) == 8'h00);
      s_en = b_en_cnt;
      run_txn(1'b1, -1, 1'b0, nd, ndn, bl, bc, dc);
      checks++;
      if (b_data !== b_pat || b_crc_ok !== exp_ok || b_en_cnt - s_en != 8 || nd != 1 + 8 * T_SLOT + 2) begin
        errors++; $display("FAIL nbytes1_%0d: data=%h crc_ok=%b en=%0d done_cycle=%0d expected %h/%b/8/%0d",
                           i, b_data, b_crc_ok, b_en_cnt - s_en, nd, b_pat, exp_ok, 1 + 8 * T_SLOT + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_bad_crc();
    test_slot_timing();
    test_rst_mid();
    test_zero_one();
    test_random();
    test_back_to_back();
    test_nbytes1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ow_scratchpad_reader.md
Name: ow_scratchpad_reader

Overview:
Master-side 1-Wire read engine for the DS18B20 path. On a start pulse it issues 8*NBYTES read time slots on the DQ line. It samples each bit LSB-first and streams every bit, as a data-bit/enable pair, into the downstream CRC8 register (x^8+x^5+x^4+1, Dallas/Maxim). It assembles the scratchpad bytes, then reads back the CRC register to flag crc_ok. The reset/presence pulse and ROM/function commands (e.g. 0xCC, 0xBE) are issued by the upstream command sequencer before start.

Parameters:
NBYTES, 9, bytes read per transaction (scratchpad incl. CRC byte); must be >=1
T_LOW, 100, cycles DQ is driven low at slot start (2 us @ 50 MHz); must be >=1
T_SAMPLE, 650, slot-relative cycle at which synchronized DQ is sampled (13 us); T_LOW < T_SAMPLE
T_SLOT, 3500, total slot length in cycles incl. recovery (70 us); T_SAMPLE < T_SLOT-1

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a transaction; ignored while busy
dq_in  in  1  raw DQ pin level (asynchronous); 2-FF synchronized internally
dq_oe  out  1  1 = drive DQ low (open-drain enable), 0 = release
crc_rst  out  1  one-cycle clear to CRC register (its rst)
crc_bit  out  1  sampled data bit to CRC register (its DataIn)
crc_en  out  1  one-cycle bit strobe to CRC register (its enable)
crc_val  in  8  current CRC register contents (its DataOut)
data  out  8*NBYTES  assembled scratchpad; received bit k lands in data[k] (byte 0 = data[7:0])
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at transaction end
crc_ok  out  1  valid from done; 1 iff crc_val==0 after all bits; held until next start

Behaviour:
- Reset values: dq_oe=0, crc_rst=0, crc_bit=0, crc_en=0, data=0, busy=0, done=0, crc_ok=0, state IDLE, sync flops=1.
- FSM states: IDLE, CLR, SLOT, CHECK, DONE.
- IDLE: start=1 -> CLR. Set busy=1 and clear crc_ok.
- CLR: crc_rst=1 for exactly this cycle. Bit index=0, slot counter cnt=0 -> SLOT.
- SLOT: cnt runs 0..T_SLOT-1.
  - dq_oe=1 exactly for cnt in 0..T_LOW-1, i.e. T_LOW cycles per slot. Otherwise dq_oe=0.
  - At cnt==T_SAMPLE: b = synchronized DQ. data[index] <= b, crc_bit <= b, crc_en <= 1 for one cycle.
  - At cnt==T_SLOT-1: if index==8*NBYTES-1 -> CHECK. Otherwise index++, cnt=0 and the next slot starts back-to-back.
- CHECK: one cycle, which guarantees the last crc_en has been absorbed. crc_ok <= (crc_val==8'h00) -> DONE.
- DONE: done=1 for one cycle, busy=0 on the same cycle -> IDLE.
- crc_en fires exactly 8*NBYTES times per transaction, never in CLR/CHECK/DONE, and never while crc_rst=1.
- Transaction length from start to done = 1 (CLR) + 8*NBYTES*T_SLOT + 1 (CHECK) + 1 cycles.
- start during busy: ignored, no restart.
- start on the DONE cycle: ignored. It is accepted only in IDLE.
- rst mid-transaction: next edge returns all outputs to reset values. dq_oe releases immediately and data is cleared.
- data holds its value after done until the next accepted start. It is not cleared at start; bits are overwritten as received.
- Sync delay of 2 cycles on dq_in is accounted for in T_SAMPLE by the integrator; the block applies no compensation.

Test Plan:
- Sim params T_LOW=4, T_SAMPLE=20, T_SLOT=60, NBYTES=9, real CRC8 register attached. DS18B20 model returns 50 05 4B 46 7F FF 0C 10 1C LSB-first -> data=72'h1C_10_0C_FF_7F_46_4B_05_50, crc_ok=1, done 1+72*60+2 cycles after start.
- Same data with byte 2 = 4A -> crc_ok=0, data byte 2 = 4A, done timing unchanged.
- Slot timing check: count dq_oe high runs -> exactly 72 runs of 4 cycles each, run starts 60 cycles apart; crc_en pulses=72, each at slot cycle 20; crc_rst single pulse before first dq_oe.
- Model holds DQ low for all slots (all-zero read) -> data=0, crc_val stays 0 so crc_ok=1; model holds DQ high -> data all ones, crc_ok=0.
- start re-pulsed at slot 10 and on DONE cycle -> no restart, single done; rst asserted at slot 30 during dq_oe=1 -> next cycle dq_oe=0, busy=0, data=0, crc_ok=0, and a fresh start then completes normally.
- NBYTES=1, DQ pattern 0xA5 -> data=8'hA5, 8 crc_en pulses, crc_ok reflects crc_val (nonzero -> 0).
